// File: rtl/rx_crc_chk.sv
// rx_crc_chk: frame-level controller behind the serial CRC division engine.
// Accepts a codeword, pulses the engine start, waits for the remainder (or a
// timeout), judges the frame and hands the payload downstream with an error
// flag. Keeps saturating frame/error statistics.
//
// Optional build macro RX_CRC_DROP_EN: when defined, errored frames (CRC or
// timeout) are dropped instead of presented; they still count in err_cnt_o.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high. Once valid is raised by a source it is held, together with its
// data, until that transfer edge; ready may change freely and never depends on
// valid combinationally.
module rx_crc_chk #(
    parameter int CRC_LENGTH  = 8,
    parameter int DATA_LENGTH = 32,
    parameter int TIMEOUT     = 40,
    parameter int CNT_W       = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [CRC_LENGTH+DATA_LENGTH-1:0] frm_i,
    input  logic                              frm_vld_i,
    output logic                              frm_rdy_o,
    output logic [CRC_LENGTH+DATA_LENGTH-1:0] crc_din_o,
    output logic                              crc_start_o,
    input  logic [CRC_LENGTH:0]               crc_rem_i,
    input  logic                              crc_vld_i,
    output logic [DATA_LENGTH-1:0]            data_o,
    output logic                              data_vld_o,
    input  logic                              data_rdy_i,
    output logic                              data_err_o,
    output logic                              timeout_o,
    output logic [CNT_W-1:0]                  frm_cnt_o,
    output logic [CNT_W-1:0]                  err_cnt_o,
    output logic [1:0]                        dbg_state
);

    localparam int FW = CRC_LENGTH + DATA_LENGTH;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [FW-1:0]   buf_q;
    logic [TW-1:0]   tcnt_q;
    logic            err_q;
    logic            to_q;
    logic            live_q;
    logic [CNT_W-1:0] frm_cnt_q;
    logic [CNT_W-1:0] err_cnt_q;

    logic accept;
    logic deliver;
    logic expire;
    logic judge;
    logic judge_err;
    logic frm_inc;
    logic err_inc;
    logic unused_rem_msb;

    // The remainder MSB carries no information for the pass/fail decision.
    assign unused_rem_msb = crc_rem_i[CRC_LENGTH];

    assign accept  = frm_vld_i && frm_rdy_o;
    assign deliver = data_vld_o && data_rdy_i;
    // The counter is 0 in the first WAIT cycle; expiry fires when its next
    // value would reach TIMEOUT-1, so data_vld_o rises TIMEOUT cycles after
    // the start pulse.
    assign expire    = (tcnt_q == TW'(TIMEOUT - 2));
    // A result pulse in the expiry cycle wins over the timeout.
    assign judge     = (state_q == S_WAIT) && (crc_vld_i || expire);
    assign judge_err = crc_vld_i ? (crc_rem_i[CRC_LENGTH-1:0] != '0) : 1'b1;

    assign frm_inc = deliver;
`ifdef RX_CRC_DROP_EN
    assign err_inc = judge && judge_err;
`else
    assign err_inc = deliver && err_q;
`endif

    // State register; reset discards any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (judge) begin
`ifdef RX_CRC_DROP_EN
                    state_d = judge_err ? S_IDLE : S_OUT;
`else
                    state_d = S_OUT;
`endif
                end
            end
            S_OUT:   if (deliver) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; ready is held low until the first clock
    // after reset release so every output reads 0 while in reset.
    always_comb begin
        frm_rdy_o   = live_q && (state_q == S_IDLE);
        crc_start_o = (state_q == S_START);
        data_vld_o  = (state_q == S_OUT);
    end

    // Frame buffer, timeout counter and verdict flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q  <= '0;
            tcnt_q <= '0;
            err_q  <= 1'b0;
            to_q   <= 1'b0;
            live_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
            if (accept) begin
                buf_q <= frm_i;
                err_q <= 1'b0;
                to_q  <= 1'b0;
            end
            if (state_q == S_START)     tcnt_q <= '0;
            else if (state_q == S_WAIT) tcnt_q <= tcnt_q + TW'(1);
            if (judge) begin
                err_q <= judge_err;
                to_q  <= !crc_vld_i;
            end
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            if (frm_inc && (frm_cnt_q != '1)) frm_cnt_q <= frm_cnt_q + CNT_W'(1);
            if (err_inc && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
    end

    assign crc_din_o  = buf_q;
    assign data_o     = buf_q[FW-1:CRC_LENGTH];
    assign data_err_o = err_q;
    assign timeout_o  = to_q;
    assign frm_cnt_o  = frm_cnt_q;
    assign err_cnt_o  = err_cnt_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_rx_crc_chk.sv
// Directed bench for rx_crc_chk: table of single-frame vectors plus
// hand-written sequences for tie, late result, backpressure, reset and
// counter saturation (second instance with 2-bit counters).
module tb_rx_crc_chk;

    localparam int CL = 8;
    localparam int DL = 32;
    localparam int TO = 40;
    localparam int FW = CL + DL;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [FW-1:0] frm_i = '0;
    logic          frm_vld_i = 1'b0;
    logic [CL:0]   crc_rem_i = '0;
    logic          crc_vld_i = 1'b0;
    logic          data_rdy_i = 1'b0;

    logic          frm_rdy_o, crc_start_o, data_vld_o, data_err_o, timeout_o;
    logic [FW-1:0] crc_din_o;
    logic [DL-1:0] data_o;
    logic [15:0]   frm_cnt_o, err_cnt_o;
    logic [1:0]    dbg_state;

    logic          s_frm_rdy, s_crc_start, s_data_vld, s_data_err, s_timeout;
    logic [FW-1:0] s_crc_din;
    logic [DL-1:0] s_data;
    logic [1:0]    s_frm_cnt, s_err_cnt, s_dbg_state;

    rx_crc_chk #(.CRC_LENGTH(CL), .DATA_LENGTH(DL), .TIMEOUT(TO), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .frm_i(frm_i), .frm_vld_i(frm_vld_i),
        .frm_rdy_o(frm_rdy_o), .crc_din_o(crc_din_o), .crc_start_o(crc_start_o),
        .crc_rem_i(crc_rem_i), .crc_vld_i(crc_vld_i), .data_o(data_o),
        .data_vld_o(data_vld_o), .data_rdy_i(data_rdy_i), .data_err_o(data_err_o),
        .timeout_o(timeout_o), .frm_cnt_o(frm_cnt_o), .err_cnt_o(err_cnt_o),
        .dbg_state(dbg_state)
    );

    rx_crc_chk #(.CRC_LENGTH(CL), .DATA_LENGTH(DL), .TIMEOUT(TO), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .frm_i(frm_i), .frm_vld_i(frm_vld_i),
        .frm_rdy_o(s_frm_rdy), .crc_din_o(s_crc_din), .crc_start_o(s_crc_start),
        .crc_rem_i(crc_rem_i), .crc_vld_i(crc_vld_i), .data_o(s_data),
        .data_vld_o(s_data_vld), .data_rdy_i(data_rdy_i), .data_err_o(s_data_err),
        .timeout_o(s_timeout), .frm_cnt_o(s_frm_cnt), .err_cnt_o(s_err_cnt),
        .dbg_state(s_dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int exp_frm = 0;
    int exp_err = 0;
    logic [DL-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks (all entered/left at a negedge) ----------------
    // Offer a codeword, wait for acceptance; returns in the START cycle.
    task automatic send(input logic [DL-1:0] p, input logic [CL-1:0] c);
        int n;
        n = 0;
        frm_i = {p, c};
        frm_vld_i = 1'b1;
        while (frm_rdy_o !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept_bound", 64'(n < 200), 64'd1);
        @(negedge clk);
        frm_vld_i = 1'b0;
        check("start_pulse", 64'(crc_start_o), 64'd1);
        check("crc_din", 64'(crc_din_o), 64'({p, c}));
        exp_q.push_back(p);
    endtask

    // Engine stub: result pulse 'delay' cycles after the start cycle (0 = never).
    task automatic engine(input int delay, input logic [CL:0] rem);
        @(negedge clk);
        check("start_single", 64'(crc_start_o), 64'd0);
        if (delay > 0) begin
            repeat (delay - 1) @(negedge clk);
            crc_rem_i = rem;
            crc_vld_i = 1'b1;
            @(negedge clk);
            crc_vld_i = 1'b0;
            crc_rem_i = '0;
        end
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (data_vld_o !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("out_bound", 64'(n < 100), 64'd1);
    endtask

    // Check presented frame, complete the output handshake, check counters.
    task automatic finish_frame(input logic e, input logic t);
        logic [DL-1:0] p;
        p = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("data_o", 64'(data_o), 64'(p));
        check("data_err", 64'(data_err_o), 64'(e));
        check("timeout", 64'(timeout_o), 64'(t));
        data_rdy_i = 1'b1;
        @(negedge clk);
        data_rdy_i = 1'b0;
        exp_frm++;
        if (e) exp_err++;
        check("vld_drop", 64'(data_vld_o), 64'd0);
        check("frm_cnt", 64'(frm_cnt_o), 64'(exp_frm));
        check("err_cnt", 64'(err_cnt_o), 64'(exp_err));
    endtask

    typedef struct {
        logic [DL-1:0] pay;
        logic [CL-1:0] crc;
        int            delay;
        logic [CL:0]   rem;
        logic          err;
        logic          to;
        int            lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic ok;

        vecs[0] = '{32'hDEADBEEF, 8'h3C, DL, 9'h000, 1'b0, 1'b0, 0};
        vecs[1] = '{32'h12345678, 8'h11, DL, 9'h05A, 1'b1, 1'b0, 0};
        vecs[2] = '{32'hCAFEF00D, 8'h22, DL, 9'h100, 1'b0, 1'b0, 0};
        vecs[3] = '{32'hA5A5A5A5, 8'h33, DL, 9'h001, 1'b1, 1'b0, 0};
        vecs[4] = '{32'h00000000, 8'h44, DL, 9'h080, 1'b1, 1'b0, 0};
        vecs[5] = '{32'hFFFFFFFF, 8'h55, 0,  9'h000, 1'b1, 1'b1, TO - 1};

        // reset state
        #12;
        check("rst_rdy", 64'(frm_rdy_o), 64'd0);
        check("rst_vld", 64'(data_vld_o), 64'd0);
        check("rst_din", 64'(crc_din_o), 64'd0);
        check("rst_frm_cnt", 64'(frm_cnt_o), 64'd0);
        check("rst_err_cnt", 64'(err_cnt_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rdy_after_rst", 64'(frm_rdy_o), 64'd1);

        // table-driven single frames
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].pay, vecs[i].crc);
            engine(vecs[i].delay, vecs[i].rem);
            wait_out(n);
            check("latency", 64'(n), 64'(vecs[i].lat));
            finish_frame(vecs[i].err, vecs[i].to);
        end

        // result pulse in the expiry cycle: result wins, no timeout
        send(32'h0BADF00D, 8'h66);
        engine(TO - 1, 9'h000);
        wait_out(n);
        check("tie_latency", 64'(n), 64'd0);
        finish_frame(1'b0, 1'b0);

        // late result after a timeout has no effect
        send(32'h13579BDF, 8'h77);
        engine(0, 9'h000);
        wait_out(n);
        check("to_latency", 64'(n + 1), 64'(TO));
        crc_rem_i = 9'h000;
        crc_vld_i = 1'b1;
        @(negedge clk);
        crc_vld_i = 1'b0;
        check("late_vld_hold", 64'(data_vld_o), 64'd1);
        finish_frame(1'b1, 1'b1);

        // backpressure with a second frame waiting
        send(32'h11112222, 8'h01);
        engine(DL, 9'h000);
        wait_out(n);
        frm_i = {32'h33334444, 8'h02};
        frm_vld_i = 1'b1;
        ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (data_o !== 32'h11112222 || frm_rdy_o !== 1'b0 || data_vld_o !== 1'b1) ok = 1'b0;
            @(negedge clk);
        end
        check("bp_hold", 64'(ok), 64'd1);
        finish_frame(1'b0, 1'b0);
        check("bp_rdy_idle", 64'(frm_rdy_o), 64'd1);
        @(negedge clk);
        frm_vld_i = 1'b0;
        check("bp_second_start", 64'(crc_start_o), 64'd1);
        check("bp_second_din", 64'(crc_din_o), 64'({32'h33334444, 8'h02}));
        exp_q.push_back(32'h33334444);
        engine(DL, 9'h000);
        wait_out(n);
        finish_frame(1'b0, 1'b0);

        // reset in the middle of WAIT
        send(32'h55556666, 8'h03);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rdy", 64'(frm_rdy_o), 64'd0);
        check("mid_rst_start", 64'(crc_start_o), 64'd0);
        check("mid_rst_vld", 64'(data_vld_o), 64'd0);
        check("mid_rst_data", 64'(data_o), 64'd0);
        check("mid_rst_din", 64'(crc_din_o), 64'd0);
        check("mid_rst_frm_cnt", 64'(frm_cnt_o), 64'd0);
        check("mid_rst_err_cnt", 64'(err_cnt_o), 64'd0);
        exp_frm = 0;
        exp_err = 0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_rdy", 64'(frm_rdy_o), 64'd1);
        check("post_rst_sat_cnt", 64'({s_frm_cnt, s_err_cnt}), 64'd0);

        // saturation: five bad frames, 2-bit instance sticks at 3
        for (int i = 0; i < 5; i++) begin
            send(32'h0000A000 + 32'(i), 8'h0F);
            engine(DL, 9'h05A);
            wait_out(n);
            finish_frame(1'b1, 1'b0);
        end
        check("sat_frm_cnt", 64'(s_frm_cnt), 64'd3);
        check("sat_err_cnt", 64'(s_err_cnt), 64'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
